// File: rtl/sar_ctrl_pkg.sv
// rtl/sar_ctrl_pkg.sv - shared phase encoding and sizing helpers for the SAR conversion controller
package sar_ctrl_pkg;

   // Encoding is also decoded by the SAR timer from StateP; do not renumber.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_SAMPLE  = 2'b01,
      ST_CONVERT = 2'b10,
      ST_DONE    = 2'b11
   } sar_state_e;

   function automatic int cnt_width(input int sample_cyc, input int settle);
      return $clog2(((sample_cyc > settle) ? sample_cyc : settle) + 1);
   endfunction

endpackage

// File: rtl/sar_phase_counter.sv
// rtl/sar_phase_counter.sv - loadable down-counter timing both the sample and settle intervals
module sar_phase_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sar_conv_controller.sv
// rtl/sar_conv_controller.sv - sample/convert sequencer running a bit-serial binary search on DacCode
module sar_conv_controller
   import sar_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SAMPLE_CYC = 8,
   parameter int SETTLE     = 4
) (
   input  logic             ClockT,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Abort,
   input  logic             CompIn,
   input  logic             Ack,
   output logic             SampleEn,
   output logic [WIDTH-1:0] DacCode,
   output logic [1:0]       StateP,
   output logic             Busy,
   output logic [WIDTH-1:0] Result,
   output logic             Valid
);

   localparam int CNT_W = cnt_width(SAMPLE_CYC, SETTLE);
   localparam int BIT_W = $clog2(WIDTH);

   sar_state_e       state_q, state_d;
   logic             sample_en_q, sample_en_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] dac_q, dac_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [WIDTH-1:0] code;
   logic             to_idle;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;

   sar_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk_i      (ClockT),
      .rst_n_i    (Reset),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      sample_en_d = sample_en_q;
      valid_d     = valid_q;
      dac_d       = dac_q;
      result_d    = result_q;
      bit_d       = bit_q;
      code        = dac_q;
      to_idle     = 1'b0;
      cnt_load    = 1'b0;
      cnt_val     = '0;

      case (state_q)
         ST_IDLE: begin
            if (Start && !Abort) begin
               state_d     = ST_SAMPLE;
               sample_en_d = 1'b1;
               cnt_load    = 1'b1;
               cnt_val     = CNT_W'(SAMPLE_CYC - 1);
            end
         end
         ST_SAMPLE: begin
            if (Abort) begin
               to_idle = 1'b1;
            end else if (cnt_zero) begin
               state_d     = ST_CONVERT;
               sample_en_d = 1'b0;
               bit_d       = BIT_W'(WIDTH - 1);
               dac_d       = {1'b1, {(WIDTH-1){1'b0}}};
               cnt_load    = 1'b1;
               cnt_val     = CNT_W'(SETTLE - 1);
            end
         end
         ST_CONVERT: begin
            if (Abort) begin
               to_idle = 1'b1;
            end else if (cnt_zero) begin
               // Resolve the bit on trial, then arm the next lower bit.
               code[bit_q] = CompIn;
               if (bit_q != '0) begin
                  code[bit_q - BIT_W'(1)] = 1'b1;
                  bit_d    = bit_q - BIT_W'(1);
                  cnt_load = 1'b1;
                  cnt_val  = CNT_W'(SETTLE - 1);
               end else begin
                  result_d = code;
                  valid_d  = 1'b1;
                  state_d  = ST_DONE;
               end
               dac_d = code;
            end
         end
         ST_DONE: begin
            if (Ack || Abort) begin
               to_idle = 1'b1;
            end
         end
         default: to_idle = 1'b1;
      endcase

      if (to_idle) begin
         state_d     = ST_IDLE;
         sample_en_d = 1'b0;
         valid_d     = 1'b0;
         dac_d       = '0;
         cnt_load    = 1'b1;
         cnt_val     = '0;
      end

      busy_d = (state_d == ST_SAMPLE) || (state_d == ST_CONVERT);
   end

   always_ff @(posedge ClockT or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         sample_en_q <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         dac_q       <= '0;
         result_q    <= '0;
         bit_q       <= '0;
      end else begin
         state_q     <= state_d;
         sample_en_q <= sample_en_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         dac_q       <= dac_d;
         result_q    <= result_d;
         bit_q       <= bit_d;
      end
   end

   assign StateP   = state_q;
   assign SampleEn = sample_en_q;
   assign Busy     = busy_q;
   assign Valid    = valid_q;
   assign DacCode  = dac_q;
   assign Result   = result_q;

endmodule

// File: doc/sar_conv_controller.md
Name: sar_conv_controller

Overview:
Sequencer for the 8-bit successive-approximation conversion datapath. It accepts a Start request, runs a timed sample phase, then performs a bit-serial binary search on the trial code driven to the DAC. Each bit is resolved from the comparator output after a settle interval. It publishes StateP in the encoding the SAR timer consumes, and presents Result with a Valid/Ack handshake.

Parameters:
WIDTH, 8, conversion resolution in bits (>=2)
SAMPLE_CYC, 8, cycles SampleEn is held high (>=1)
SETTLE, 4, cycles per bit trial before CompIn is sampled (>=1)

Ports:
ClockT  input  1  single system clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Start  input  1  conversion request, sampled only in IDLE
Abort  input  1  synchronous abort of any conversion in progress
CompIn  input  1  comparator: 1 = analog input >= DacCode
Ack  input  1  consumer accepts Result
SampleEn  output  1  track/hold switch enable
DacCode  output  WIDTH  trial code driven to the DAC
StateP  output  2  phase: 00 IDLE, 01 SAMPLE, 10 CONVERT, 11 DONE
Busy  output  1  high in SAMPLE or CONVERT
Result  output  WIDTH  final code, stable while Valid
Valid  output  1  Result available

Behaviour:
- Reset low: state IDLE, StateP=00, SampleEn=0, DacCode=0, Result=0, Valid=0, Busy=0, all counters 0. Reset may assert at any time; it discards an in-flight conversion immediately.
- All outputs are registered. StateP is a direct copy of the state register.
- IDLE: if Start=1 at an edge (and Abort=0), go to SAMPLE. Phase counter is loaded with SAMPLE_CYC-1. SampleEn=1 from that edge.
- SAMPLE: counter decrements each cycle. When the counter reaches 0, go to CONVERT on the next edge:
  - SampleEn=0.
  - Bit index = WIDTH-1.
  - DacCode = 1 followed by WIDTH-1 zeros (MSB trial).
  - Counter = SETTLE-1.
- CONVERT, per bit i:
  - The counter counts down. On the edge where the counter is 0, CompIn is sampled.
  - CompIn=1 keeps bit i at 1. CompIn=0 clears bit i.
  - If i>0, set bit i-1 in DacCode, i decrements, and the counter reloads with SETTLE-1.
  - If i=0, Result takes the resolved code (the same edge writes DacCode), Valid=1, and the state goes to DONE.
- Bits above i are final. Bits below i are 0 during a trial.
- Latency: Valid rises exactly SAMPLE_CYC + WIDTH*SETTLE cycles after the edge that sampled Start.
- DONE: Valid=1, Result and DacCode held. On an edge with Ack=1: Valid=0, go to IDLE.
  - Start in DONE is ignored, even with Ack in the same cycle. A new Start is honoured from IDLE, one cycle later at the earliest.
  - Ack outside DONE is ignored.
- Start while Busy or in DONE is ignored. No queuing.
- Abort=1 in SAMPLE or CONVERT: next edge goes to IDLE, SampleEn=0, DacCode=0, no Valid, Result unchanged.
- Abort in DONE behaves as Ack.
- Abort in IDLE has priority over Start, so no conversion begins.
- Busy = (StateP==01 || StateP==10).
- Arithmetic: the bit index is a $clog2(WIDTH)-bit counter. The phase counter width is $clog2(max(SAMPLE_CYC,SETTLE)+1). No wrap-around is possible. Unused counter states return to IDLE.

Decomposition:
- Package sar_ctrl_pkg holds:
  - state constants ST_IDLE=2'b00, ST_SAMPLE=2'b01, ST_CONVERT=2'b10, ST_DONE=2'b11, shared with the SAR timer's StateP decode;
  - a function returning the counter width.
- One sub-module, sar_phase_counter: a loadable down-counter with load value, load strobe and zero flag. It is reused for both the SAMPLE and SETTLE intervals.
- The FSM and the bit register stay in sar_conv_controller.

Test Plan:
All cases use WIDTH=8, SAMPLE_CYC=4, SETTLE=2. The bench comparator model is CompIn = (Vin >= DacCode).
1. Vin=0xA5, Start pulse -> DacCode trials 80,C0,A0,B0,A8,A4,A6,A5. Valid rises 20 cycles after the Start edge with Result=0xA5. StateP follows 01(4 cycles), 10(16 cycles), 11.
2. Vin=0x00 and Vin=0xFF -> Result=0x00 (all trials rejected) and 0xFF (all kept), each with 20-cycle latency.
3. Ack withheld 10 cycles after Valid, Start pulsed in DONE -> Valid and Result=0xA5 stay stable. After Ack: one IDLE cycle, Start ignored, and no new conversion starts until Start is reissued in IDLE.
4. Start repulsed mid-CONVERT with a different Vin -> ignored. The original conversion completes with its Result, and no second Valid appears.
5. Abort at cycle 9 of a conversion -> next edge StateP=00, DacCode=0, SampleEn=0, Valid never rises. A following Start converts normally.
6. Reset driven low at cycle 12 of a conversion (asynchronous, mid-cycle) -> all outputs go to their reset values immediately. After release, the block is in IDLE, and Start gives a correct 20-cycle conversion.
